// File: rtl/datapath_mc.sv
`default_nettype none
// ============================================================================
// Module   : datapath_mc
// Purpose  : Multi-cycle register-file / ALU / RAM datapath. Accepts one
//            micro-op at a time over a valid/ready handshake and executes
//            ALU, LOAD and STORE ops through an internal FSM backed by a
//            synchronous-read RAM. Completion is signalled by a one-cycle
//            done pulse together with the result and status flags.
// Ports    :
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   op_valid_i     micro-op present
//   op_ready_o     block can accept (high only in IDLE)
//   op_i           0=ALU 1=LOAD 2=STORE 3=reserved (NOP)
//   fs_i           ALU function: ADD SUB AND OR XOR SHL SHR PASS_B
//   use_imm_i      ALU operand B taken from imm_i instead of the register file
//   wr_addr_i      destination register (ALU, LOAD)
//   rd_addr_a_i    source A / base address register
//   rd_addr_b_i    source B / store data register
//   imm_i          immediate / address offset
//   done_o         one-cycle completion pulse
//   result_o       ALU result, loaded word, stored word or faulting address
//   mem_err_o      effective address out of range (valid with done_o)
//   zero_o/neg_o/carry_o/ovf_o  ALU status, updated by ALU ops only
// Revision : 1.0 - initial release
// ============================================================================
module datapath_mc #(
  parameter int WIDTH     = 64,
  parameter int REGS      = 32,
  parameter int RAM_DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic [1:0]               op_i,
  input  logic [2:0]               fs_i,
  input  logic                     use_imm_i,
  input  logic [$clog2(REGS)-1:0]  wr_addr_i,
  input  logic [$clog2(REGS)-1:0]  rd_addr_a_i,
  input  logic [$clog2(REGS)-1:0]  rd_addr_b_i,
  input  logic [WIDTH-1:0]         imm_i,
  output logic                     done_o,
  output logic [WIDTH-1:0]         result_o,
  output logic                     mem_err_o,
  output logic                     zero_o,
  output logic                     neg_o,
  output logic                     carry_o,
  output logic                     ovf_o
);

  localparam int RA = $clog2(REGS);
  localparam int MA = $clog2(RAM_DEPTH);
  localparam int SA = $clog2(WIDTH);

  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  localparam logic [2:0] FS_ADD  = 3'd0;
  localparam logic [2:0] FS_SUB  = 3'd1;
  localparam logic [2:0] FS_AND  = 3'd2;
  localparam logic [2:0] FS_OR   = 3'd3;
  localparam logic [2:0] FS_XOR  = 3'd4;
  localparam logic [2:0] FS_SHL  = 3'd5;
  localparam logic [2:0] FS_SHR  = 3'd6;
  localparam logic [2:0] FS_PASS = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e state_q;

  // Latched micro-op
  logic [1:0]       op_q;
  logic [2:0]       fs_q;
  logic             use_imm_q;
  logic [RA-1:0]    wr_addr_q;
  logic [RA-1:0]    rd_addr_a_q;
  logic [RA-1:0]    rd_addr_b_q;
  logic [WIDTH-1:0] imm_q;

  // Architectural storage
  logic [WIDTH-1:0] regs_q [REGS];
  logic [WIDTH-1:0] mem_q  [RAM_DEPTH];
  logic [MA-1:0]    mem_addr_q;
  logic [WIDTH-1:0] mem_rdata_q;

  // Registered outputs
  logic             op_ready_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             mem_err_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;

  // EXEC-cycle combinational values
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic [WIDTH-1:0] opb2_d;
  logic [WIDTH:0]   add_d;
  logic [WIDTH:0]   sub_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_c_d;
  logic             alu_v_d;
  logic [WIDTH-1:0] ea_d;
  logic             ea_ok_d;
  logic             mem_we_d;

  always_comb begin
    opa_d  = regs_q[rd_addr_a_q];
    opb_d  = regs_q[rd_addr_b_q];
    opb2_d = use_imm_q ? imm_q : opb_d;

    // Extra MSB captures carry-out; SUB uses A + ~B + 1 so the MSB is the
    // no-borrow indication.
    add_d = {1'b0, opa_d} + {1'b0, opb2_d};
    sub_d = {1'b0, opa_d} + {1'b0, ~opb2_d} + (WIDTH+1)'(1);

    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (fs_q)
      FS_ADD: begin
        alu_res_d = add_d[WIDTH-1:0];
        alu_c_d   = add_d[WIDTH];
        // Same-sign operands producing a different-sign sum
        alu_v_d   = (opa_d[WIDTH-1] == opb2_d[WIDTH-1]) &&
                    (add_d[WIDTH-1] != opa_d[WIDTH-1]);
      end
      FS_SUB: begin
        alu_res_d = sub_d[WIDTH-1:0];
        alu_c_d   = sub_d[WIDTH];
        // Different-sign operands where the difference takes B's sign
        alu_v_d   = (opa_d[WIDTH-1] != opb2_d[WIDTH-1]) &&
                    (sub_d[WIDTH-1] != opa_d[WIDTH-1]);
      end
      FS_AND:  alu_res_d = opa_d & opb2_d;
      FS_OR:   alu_res_d = opa_d | opb2_d;
      FS_XOR:  alu_res_d = opa_d ^ opb2_d;
      FS_SHL:  alu_res_d = opa_d << opb2_d[SA-1:0];
      FS_SHR:  alu_res_d = opa_d >> opb2_d[SA-1:0];
      FS_PASS: alu_res_d = opb2_d;
      default: alu_res_d = '0;
    endcase

    // Effective address wraps at WIDTH bits; the range check uses the full
    // word so wrapped-high addresses are caught.
    ea_d    = opa_d + imm_q;
    ea_ok_d = (ea_d < WIDTH'(RAM_DEPTH));

    // Gated by state, which async reset forces to IDLE, so an aborted STORE
    // never reaches the RAM.
    mem_we_d = (state_q == S_EXEC) && (op_q == OP_STORE) && ea_ok_d;
  end

  // Control FSM, register file and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      fs_q        <= '0;
      use_imm_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      imm_q       <= '0;
      mem_addr_q  <= '0;
      op_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
      mem_err_q   <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid_i && op_ready_q) begin
            op_q        <= op_i;
            fs_q        <= fs_i;
            use_imm_q   <= use_imm_i;
            wr_addr_q   <= wr_addr_i;
            rd_addr_a_q <= rd_addr_a_i;
            rd_addr_b_q <= rd_addr_b_i;
            imm_q       <= imm_i;
            mem_err_q   <= 1'b0;
            op_ready_q  <= 1'b0;
            state_q     <= S_EXEC;
          end
        end

        S_EXEC: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          case (op_q)
            OP_ALU: begin
              regs_q[wr_addr_q] <= alu_res_d;
              result_q          <= alu_res_d;
              zero_q            <= (alu_res_d == '0);
              neg_q             <= alu_res_d[WIDTH-1];
              carry_q           <= alu_c_d;
              ovf_q             <= alu_v_d;
            end
            OP_LOAD, OP_STORE: begin
              if (!ea_ok_d) begin
                mem_err_q <= 1'b1;
                result_q  <= ea_d;
              end else if (op_q == OP_STORE) begin
                result_q <= opb_d;
              end else begin
                // LOAD detours through MEM/WB before completing
                mem_addr_q <= ea_d[MA-1:0];
                state_q    <= S_MEM;
                done_q     <= 1'b0;
              end
            end
            default: ; // reserved op: completes with no side effects
          endcase
        end

        S_MEM: begin
          state_q <= S_WB;
        end

        S_WB: begin
          regs_q[wr_addr_q] <= mem_rdata_q;
          result_q          <= mem_rdata_q;
          state_q           <= S_DONE;
          done_q            <= 1'b1;
        end

        S_DONE: begin
          done_q     <= 1'b0;
          op_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end

        default: begin
          done_q     <= 1'b0;
          op_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // RAM: write at the STORE's EXEC edge, synchronous read during MEM.
  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[ea_d[MA-1:0]] <= opb_d;
    end
    if (state_q == S_MEM) begin
      mem_rdata_q <= mem_q[mem_addr_q];
    end
  end

  assign op_ready_o = op_ready_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign mem_err_o  = mem_err_q;
  assign zero_o     = zero_q;
  assign neg_o      = neg_q;
  assign carry_o    = carry_q;
  assign ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_mc
// Purpose  : Self-checking bench for datapath_mc: directed vector table,
//            back-to-back handshake, reset-abort sequences and randomized
//            ops compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_mc;

  localparam int W  = 64;
  localparam int NR = 32;
  localparam int ND = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op;
  logic [2:0]    fs;
  logic          use_imm;
  logic [4:0]    wr_addr;
  logic [4:0]    rd_addr_a;
  logic [4:0]    rd_addr_b;
  logic [W-1:0]  imm;
  logic          done;
  logic [W-1:0]  result;
  logic          mem_err;
  logic          zero_f, neg_f, carry_f, ovf_f;

  always #5 clk = ~clk;

  datapath_mc #(.WIDTH(W), .REGS(NR), .RAM_DEPTH(ND)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_i        (op),
    .fs_i        (fs),
    .use_imm_i   (use_imm),
    .wr_addr_i   (wr_addr),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .imm_i       (imm),
    .done_o      (done),
    .result_o    (result),
    .mem_err_o   (mem_err),
    .zero_o      (zero_f),
    .neg_o       (neg_f),
    .carry_o     (carry_f),
    .ovf_o       (ovf_f)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model state ----------------
  logic [W-1:0] mregs [NR];
  logic [W-1:0] mram  [ND];
  logic [W-1:0] mres;
  logic [3:0]   mfl;   // {zero, neg, carry, ovf}

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mres = '0;
    mfl  = 4'b0000;
  endtask

  // Architectural effect of one op; returns the expected observables.
  task automatic model_op(input logic [1:0] o, input logic [2:0] f, input logic ui,
                          input int wa, input int ra, input int rb, input logic [W-1:0] im,
                          output logic [W-1:0] er, output logic ee,
                          output logic [3:0] ef, output int el);
    logic [W-1:0] a, b, bp, r, ea;
    logic signed [W:0] s;
    logic c, v;
    a  = mregs[ra];
    b  = mregs[rb];
    bp = ui ? im : b;
    el = 2;
    ee = 1'b0;
    if (o == 2'd0) begin
      c = 1'b0; v = 1'b0; r = '0; s = '0;
      case (f)
        3'd0: begin
          r = a + bp;
          c = (r < a);
          s = $signed({a[W-1], a}) + $signed({bp[W-1], bp});
          v = (s != $signed({r[W-1], r}));
        end
        3'd1: begin
          r = a - bp;
          c = (a >= bp);
          s = $signed({a[W-1], a}) - $signed({bp[W-1], bp});
          v = (s != $signed({r[W-1], r}));
        end
        3'd2: r = a & bp;
        3'd3: r = a | bp;
        3'd4: r = a ^ bp;
        3'd5: r = a << bp[5:0];
        3'd6: r = a >> bp[5:0];
        default: r = bp;
      endcase
      mregs[wa] = r;
      mres = r;
      mfl  = {(r == '0), r[W-1], c, v};
    end else if (o == 2'd1 || o == 2'd2) begin
      ea = a + im;
      if (ea >= W'(ND)) begin
        ee   = 1'b1;
        mres = ea;
      end else if (o == 2'd2) begin
        mram[ea[7:0]] = b;
        mres = b;
      end else begin
        mres = mram[ea[7:0]];
        mregs[wa] = mres;
        el = 4;
      end
    end
    er = mres;
    ef = mfl;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op from IDLE and check latency, outputs and the pulse width.
  // Latency n = number of negedges after the accept edge until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [2:0] f, input logic ui,
                        input int wa, input int ra, input int rb, input logic [W-1:0] im,
                        input string tag, input logic [W-1:0] e_res, input logic e_err,
                        input logic [3:0] e_fl, input int e_lat);
    int n;
    @(negedge clk);
    chk({tag, " ready"}, W'(op_ready), W'(1));
    op = o; fs = f; use_imm = ui;
    wr_addr = 5'(wa); rd_addr_a = 5'(ra); rd_addr_b = 5'(rb); imm = im;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    n = 1;
    while (!done && n < 12) begin
      chk({tag, " busy"}, W'(op_ready), W'(0));
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, W'(n), W'(e_lat));
    chk({tag, " result"}, result, e_res);
    chk({tag, " mem_err"}, W'(mem_err), W'(e_err));
    chk({tag, " flags"}, W'({zero_f, neg_f, carry_f, ovf_f}), W'(e_fl));
    @(negedge clk);
    chk({tag, " done pulse"}, W'(done), W'(0));
  endtask

  // Random / fill ops: expectations come from the model.
  task automatic step(input logic [1:0] o, input logic [2:0] f, input logic ui,
                      input int wa, input int ra, input int rb, input logic [W-1:0] im,
                      input string tag);
    logic [W-1:0] er; logic ee; logic [3:0] ef; int el;
    model_op(o, f, ui, wa, ra, rb, im, er, ee, ef, el);
    run_op(o, f, ui, wa, ra, rb, im, tag, er, ee, ef, el);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [2:0]   fs;
    logic         ui;
    int           wa, ra, rb;
    logic [W-1:0] imm;
    logic [W-1:0] res;
    logic         err;
    logic [3:0]   fl;
    int           lat;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] er, ea_t, saved;
    logic ee; logic [3:0] ef; int el;
    int acc, dn;
    logic prev_done;

    //          op   fs    ui wa ra rb imm                     res                     err fl      lat
    tbl[0]  = '{2'd0, 3'd0, 1, 1, 0, 0, 64'd5,                  64'd5,                  0, 4'b0000, 2};
    tbl[1]  = '{2'd0, 3'd1, 1, 3, 1, 0, 64'd5,                  64'd0,                  0, 4'b1010, 2};
    tbl[2]  = '{2'd0, 3'd0, 1, 4, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'b0000, 2};
    tbl[3]  = '{2'd0, 3'd0, 1, 5, 4, 0, 64'd1,                  64'h8000_0000_0000_0000, 0, 4'b0101, 2};
    tbl[4]  = '{2'd2, 3'd0, 0, 0, 0, 1, 64'd255,                64'd5,                  0, 4'b0101, 2};
    tbl[5]  = '{2'd1, 3'd0, 0, 2, 0, 0, 64'd255,                64'd5,                  0, 4'b0101, 4};
    tbl[6]  = '{2'd1, 3'd0, 0, 6, 0, 0, 64'd256,                64'd256,                1, 4'b0101, 2};
    tbl[7]  = '{2'd0, 3'd7, 0, 6, 0, 6, 64'd0,                  64'd0,                  0, 4'b1000, 2};
    tbl[8]  = '{2'd0, 3'd7, 0, 2, 0, 2, 64'd0,                  64'd5,                  0, 4'b0000, 2};
    tbl[9]  = '{2'd3, 3'd0, 1, 9, 1, 1, 64'd77,                 64'd5,                  0, 4'b0000, 2};
    tbl[10] = '{2'd0, 3'd5, 1, 7, 1, 0, 64'd4,                  64'd80,                 0, 4'b0000, 2};
    tbl[11] = '{2'd0, 3'd6, 1, 7, 7, 0, 64'd3,                  64'd10,                 0, 4'b0000, 2};
    tbl[12] = '{2'd0, 3'd1, 1, 8, 1, 0, 64'd6,                  64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b0100, 2};
    tbl[13] = '{2'd0, 3'd2, 0, 10, 8, 7, 64'd0,                 64'd10,                 0, 4'b0000, 2};
    tbl[14] = '{2'd0, 3'd3, 1, 10, 7, 0, 64'd5,                 64'd15,                 0, 4'b0000, 2};
    tbl[15] = '{2'd0, 3'd4, 1, 11, 10, 0, 64'hF,                64'd0,                  0, 4'b1000, 2};
    tbl[16] = '{2'd0, 3'd7, 0, 9, 0, 9, 64'd0,                  64'd0,                  0, 4'b1000, 2};
    tbl[17] = '{2'd0, 3'd0, 1, 12, 8, 0, 64'd1,                 64'd0,                  0, 4'b1010, 2};
    tbl[18] = '{2'd0, 3'd5, 1, 14, 1, 0, 64'd65,                64'd10,                 0, 4'b0000, 2};
    tbl[19] = '{2'd2, 3'd0, 0, 0, 8, 14, 64'd256,               64'd10,                 0, 4'b0000, 2};
    tbl[20] = '{2'd1, 3'd0, 0, 13, 0, 0, 64'd255,               64'd10,                 0, 4'b0000, 4};

    rst_n = 1'b0; op_valid = 1'b0; op = '0; fs = '0; use_imm = 1'b0;
    wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; imm = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset op_ready", W'(op_ready), W'(1));
    chk("reset done", W'(done), W'(0));
    chk("reset result", result, '0);
    chk("reset mem_err", W'(mem_err), W'(0));
    chk("reset flags", W'({zero_f, neg_f, carry_f, ovf_f}), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset op_ready", W'(op_ready), W'(1));

    // Directed table
    for (int i = 0; i < NV; i++) begin
      model_op(tbl[i].op, tbl[i].fs, tbl[i].ui, tbl[i].wa, tbl[i].ra, tbl[i].rb, tbl[i].imm,
               er, ee, ef, el);
      run_op(tbl[i].op, tbl[i].fs, tbl[i].ui, tbl[i].wa, tbl[i].ra, tbl[i].rb, tbl[i].imm,
             $sformatf("vec%0d", i), tbl[i].res, tbl[i].err, tbl[i].fl, tbl[i].lat);
    end

    // Back-to-back: op_valid held high, r15 += 1 each op
    @(negedge clk);
    op = 2'd0; fs = 3'd0; use_imm = 1'b1; wr_addr = 5'd15; rd_addr_a = 5'd15; imm = 64'd1;
    op_valid = 1'b1;
    acc = 0; dn = 0; prev_done = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (i == 20) op_valid = 1'b0;
      if (op_ready && op_valid) acc++;
      if (done) begin
        dn++;
        chk("b2b ready low at done", W'(op_ready), W'(0));
      end
      if (prev_done) chk("b2b ready after done", W'(op_ready), W'(1));
      prev_done = done;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("b2b accepts", W'(acc), W'(7));
    chk("b2b dones", W'(dn), W'(7));
    mregs[15] = 64'd7;
    step(2'd0, 3'd7, 1'b0, 15, 0, 15, 64'd0, "b2b r15");

    // Fill RAM with known words so random LOADs are fully predictable
    for (int i = 0; i < ND; i++) begin
      step(2'd0, 3'd7, 1'b1, 9, 0, 0, {$urandom, $urandom}, "fill pass");
      step(2'd2, 3'd0, 1'b0, 0, 0, 9, W'(i) - mregs[0], "fill store");
    end

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      logic [1:0] o; logic [2:0] f; logic ui; int wa, ra, rb; logic [W-1:0] im;
      o  = 2'($urandom_range(0, 3));
      f  = 3'($urandom_range(0, 7));
      ui = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 15);
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      if (o == 2'd1 || o == 2'd2) begin
        ea_t = W'($urandom_range(0, 300));
        im = ea_t - mregs[ra];
      end else if ($urandom_range(0, 3) == 0) begin
        im = W'($urandom_range(0, 127));
      end else begin
        im = {$urandom, $urandom};
      end
      step(o, f, ui, wa, ra, rb, im, $sformatf("rnd%0d", i));
    end

    // Reset during MEM of a LOAD: no done, regs cleared, RAM retained
    saved = mram[10];
    @(negedge clk);
    op = 2'd1; fs = 3'd0; use_imm = 1'b0; wr_addr = 5'd3; rd_addr_a = 5'd0;
    imm = 64'd10 - mregs[0];
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);            // EXEC
    op_valid = 1'b0;
    @(negedge clk);            // MEM
    rst_n = 1'b0;
    #1;
    chk("abort done low in reset", W'(done), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("abort op_ready", W'(op_ready), W'(1));
    chk("abort result", result, '0);
    chk("abort flags", W'({zero_f, neg_f, carry_f, ovf_f}), W'(0));
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort no done", W'(dn), W'(0));
    step(2'd0, 3'd7, 1'b0, 3, 0, 3, 64'd0, "abort r3 cleared");

    // Reset before a STORE's EXEC edge: RAM word must not change
    step(2'd0, 3'd7, 1'b1, 1, 0, 0, 64'hDEAD_BEEF, "setup r1");
    @(negedge clk);
    op = 2'd2; fs = 3'd0; use_imm = 1'b0; wr_addr = 5'd0; rd_addr_a = 5'd0;
    rd_addr_b = 5'd1; imm = 64'd10;
    op_valid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_op(2'd1, 3'd0, 1'b0, 3, 0, 0, 64'd10, "ram retained", saved, 1'b0, 4'b0000, 4);
    mregs[3] = saved;
    step(2'd0, 3'd7, 1'b0, 1, 0, 1, 64'd0, "r1 cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle register/ALU/RAM datapath.
- Accepts one micro-op at a time over a valid/ready handshake. Executes ALU, LOAD and STORE ops through an internal FSM, with a synchronous-read RAM.
- Reports completion with a one-cycle done pulse plus result and status flags.
- Sits between the instruction sequencer (upstream) and the processor top level.

Parameters:
- WIDTH, 64, datapath/register/RAM word width (>=8).
- REGS, 32, register-file entries; RA = clog2(REGS).
- RAM_DEPTH, 256, RAM words; MA = clog2(RAM_DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  micro-op present.
- op_ready  out  1  block can accept (high only in IDLE).
- op  in  2  0=ALU, 1=LOAD, 2=STORE, 3=reserved (acts as NOP).
- fs  in  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 PASS_B.
- use_imm  in  1  ALU operand B = imm instead of rdDataB.
- wr_addr  in  RA  destination register (ALU, LOAD).
- rd_addr_a  in  RA  source A / base address.
- rd_addr_b  in  RA  source B / store data.
- imm  in  WIDTH  immediate / address offset.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  ALU result, loaded word, or stored word; held until next done.
- mem_err  out  1  valid with done; RAM address out of range.
- zero, neg, carry, ovf  out  1 each  ALU status; updated only by ALU ops.

Behaviour:
- States: IDLE, EXEC, MEM, WB, DONE.
- Reset (async, reset=0):
  - FSM goes to IDLE; all REGS registers cleared to 0.
  - result=0, done=0, mem_err=0, flags=0, op_ready=1 after release.
  - RAM contents are not cleared.
- Accept: op_valid & op_ready at an edge latches op, fs, use_imm, all addresses and imm; FSM goes to EXEC. Inputs are ignored outside IDLE.
- EXEC: read A and B from the register file.
  - ALU: compute A op B' (B' = imm if use_imm else B).
    - Write wr_addr; latch result and flags; go to DONE.
  - LOAD/STORE: effective address ea = A + imm (WIDTH bits, wraps mod 2^WIDTH).
    - If ea >= RAM_DEPTH: no RAM or register access; latch mem_err=1, result=ea; go to DONE.
    - STORE (in range): RAM[ea[MA-1:0]] <= B at the EXEC edge; result=B; go to DONE.
    - LOAD (in range): go to MEM.
- MEM: synchronous RAM read; data registered at the edge; go to WB.
- WB: write wr_addr <= loaded word; result = loaded word; go to DONE.
- DONE: done=1 for exactly one cycle; op_ready=0; go to IDLE.
- mem_err is cleared on the next accept.
- Latency, accept edge to done high: ALU 2 cycles, STORE 2, LOAD 4. Reserved op: 2, no side effects.
- Throughput: one op per (latency+1) cycles. Ops are fully serialised, so no forwarding is needed.
- Arithmetic:
  - ADD: carry = carry-out.
  - SUB: A + ~B' + 1; carry = no-borrow.
  - ovf: signed overflow for ADD/SUB, 0 otherwise.
  - Shift amount is B'[clog2(WIDTH)-1:0].
  - zero = (result==0); neg = result[WIDTH-1].
- Same register used as source and destination: the read returns the old value; the write occurs at the end of the op.
- Reset asserted mid-op aborts the op:
  - No done pulse.
  - A STORE whose EXEC edge has not occurred does not write RAM.

Test Plan:
- Reset, then ALU ADD use_imm=1, rd_addr_a=0, imm=5, wr_addr=1 -> done 2 cycles after accept, result=5, zero=0; reg1=5.
- SUB with reg1=5, imm=5 -> result=0, zero=1, carry=1, ovf=0. ADD 0x7FFF..FF+1 -> neg=1, ovf=1, carry=0.
- STORE reg1 (=5) at base reg0 + imm=255, then LOAD imm=255 to wr_addr=2 -> store done at +2, load done at +4, result=5, reg2=5.
- LOAD with imm=256 (RAM_DEPTH=256) -> done at +2, mem_err=1, result=256; wr_addr register unchanged; RAM unchanged.
- op_valid held high back-to-back -> op_ready low from accept through DONE; second op accepted the cycle after done; no op dropped or duplicated.
- Assert reset during MEM of a LOAD -> no done pulse; regs read 0; op_ready=1 after release; RAM word retains its prior value.
